// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the register file and its neighbours.
//   DATA_W_DEF - default datapath width
//   REG_COUNT  - architectural registers X0..X31
//   REG_ADDR_W - register index width
//   ZERO_REG   - index that always reads zero and discards writes
package cpu_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 31;

endpackage

// File: rtl/regfile_decoder5_32.sv
// decoder5_32: write-enable generation for the register file.
//   idx_i [4:0]  - destination register index
//   en_i         - global write enable
//   en_o [31:0]  - one-hot per-register enable (all zero when en_i=0)
import cpu_pkg::*;

module decoder5_32 (
  input  logic [REG_ADDR_W-1:0] idx_i,
  input  logic                  en_i,
  output logic [REG_COUNT-1:0]  en_o
);

  always_comb begin
    en_o = '0;
    if (en_i) begin
      en_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mux32_1.sv
// mux32_1: single-bit 32:1 select, one leaf of the register read tree.
//   data_i [31:0] - one bit from each register
//   sel_i  [4:0]  - register index
//   data_o        - selected bit
import cpu_pkg::*;

module mux32_1 (
  input  logic [REG_COUNT-1:0]  data_i,
  input  logic [REG_ADDR_W-1:0] sel_i,
  output logic                  data_o
);

  assign data_o = data_i[sel_i];

endmodule

// File: rtl/regfile.sv
// regfile: 32 x DATA_W register file, one write port, two combinational
// read ports. X31 is hardwired to zero.
//   clk                  - single clock, rising edge
//   reset                - synchronous, active-low; clears X0..X30
//   RegWrite             - write enable
//   WriteRegister [4:0]  - write index
//   WriteData            - write value
//   ReadRegister1/2      - read indices
//   ReadData1/2          - read values (combinational)
// Build option: define REGFILE_BYPASS_EN to forward WriteData to a read
// port that addresses the register being written in the same cycle.
// DELAY is a gate-delay annotation for gate-level netlists; it has no
// effect on this RTL beyond a sanity check.
import cpu_pkg::*;

module regfile #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DELAY  = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [REG_ADDR_W-1:0] ReadRegister1,
  input  logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2
);

  if (DELAY < 0) begin : g_bad_delay
    $error("regfile: DELAY must be non-negative");
  end

  logic [REG_COUNT-1:0] wr_en;
  logic [DATA_W-1:0]    regs_q [ZERO_REG];
  logic [DATA_W-1:0]    regs_d [ZERO_REG];
  logic [DATA_W-1:0]    rows   [REG_COUNT];
  logic [REG_COUNT-1:0] cols   [DATA_W];
  logic [DATA_W-1:0]    mux_a;
  logic [DATA_W-1:0]    mux_b;

  decoder5_32 u_dec (
    .idx_i (WriteRegister),
    .en_i  (RegWrite),
    .en_o  (wr_en)
  );

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      // The zero register has no storage, so its enable goes nowhere.
      logic unused_we;
      assign unused_we = wr_en[i];
      assign rows[i]   = '0;
    end else begin : g_store
      always_comb begin
        regs_d[i] = regs_q[i];
        if (wr_en[i]) begin
          regs_d[i] = WriteData;
        end
      end

      // Reset wins over a write in the same cycle.
      always_ff @(posedge clk) begin
        if (!reset) begin
          regs_q[i] <= '0;
        end else begin
          regs_q[i] <= regs_d[i];
        end
      end

      assign rows[i] = regs_q[i];
    end
  end

  // Transpose to bit columns so each read bit is one 32:1 mux.
  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    for (genvar r = 0; r < REG_COUNT; r++) begin : g_col
      assign cols[b][r] = rows[r][b];
    end

    mux32_1 u_mux_a (
      .data_i (cols[b]),
      .sel_i  (ReadRegister1),
      .data_o (mux_a[b])
    );

    mux32_1 u_mux_b (
      .data_i (cols[b]),
      .sel_i  (ReadRegister2),
      .data_o (mux_b[b])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  // A discarded write to the zero register must never be forwarded.
  assign fwd_a = RegWrite && reset && (WriteRegister == ReadRegister1) &&
                 (ReadRegister1 != REG_ADDR_W'(ZERO_REG));
  assign fwd_b = RegWrite && reset && (WriteRegister == ReadRegister2) &&
                 (ReadRegister2 != REG_ADDR_W'(ZERO_REG));

  assign ReadData1 = fwd_a ? WriteData : mux_a;
  assign ReadData2 = fwd_b ? WriteData : mux_b;
`else
  assign ReadData1 = mux_a;
  assign ReadData2 = mux_b;
`endif

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int total;
  int bad;

  regfile dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] idx, input logic [63:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    ReadRegister1 = a;
    ReadRegister2 = b;
    #1;
  endtask

  task automatic test_reset;
    wr(5'd5, 64'hDEAD);
    rd(5'd5, 5'd0);
    total++;
    if (ReadData1 !== 64'hDEAD) begin
      bad++;
      $display("FAIL reset_preload got=%h want=%h", ReadData1, 64'hDEAD);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd(5'd5, 5'd0);
    total++;
    if (ReadData1 !== 64'h0) begin
      bad++;
      $display("FAIL reset_x5 got=%h want=%h", ReadData1, 64'h0);
    end
    total++;
    if (ReadData2 !== 64'h0) begin
      bad++;
      $display("FAIL reset_x0 got=%h want=%h", ReadData2, 64'h0);
    end
  endtask

  task automatic test_write_read;
    wr(5'd3, 64'h0123456789ABCDEF);
    wr(5'd7, 64'hFFFFFFFFFFFFFFFF);
    rd(5'd3, 5'd7);
    total++;
    if (ReadData1 !== 64'h0123456789ABCDEF) begin
      bad++;
      $display("FAIL wr_rd_x3 got=%h want=%h", ReadData1, 64'h0123456789ABCDEF);
    end
    total++;
    if (ReadData2 !== 64'hFFFFFFFFFFFFFFFF) begin
      bad++;
      $display("FAIL wr_rd_x7 got=%h want=%h", ReadData2, 64'hFFFFFFFFFFFFFFFF);
    end
    // both ports on the same register
    rd(5'd7, 5'd7);
    total++;
    if (ReadData1 !== ReadData2 || ReadData1 !== 64'hFFFFFFFFFFFFFFFF) begin
      bad++;
      $display("FAIL same_addr got=%h/%h want=%h", ReadData1, ReadData2, 64'hFFFFFFFFFFFFFFFF);
    end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd31;
    WriteData     = 64'h55;
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd3;
    #1;
    total++;
    if (ReadData1 !== 64'h0) begin
      bad++;
      $display("FAIL zero_same_cycle got=%h want=%h", ReadData1, 64'h0);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    rd(5'd31, 5'd3);
    total++;
    if (ReadData1 !== 64'h0) begin
      bad++;
      $display("FAIL zero_read got=%h want=%h", ReadData1, 64'h0);
    end
    total++;
    if (ReadData2 !== 64'h0123456789ABCDEF) begin
      bad++;
      $display("FAIL zero_x3_kept got=%h want=%h", ReadData2, 64'h0123456789ABCDEF);
    end
    rd(5'd7, 5'd0);
    total++;
    if (ReadData1 !== 64'hFFFFFFFFFFFFFFFF || ReadData2 !== 64'h0) begin
      bad++;
      $display("FAIL zero_others_kept got=%h/%h want=%h/%h", ReadData1, ReadData2,
               64'hFFFFFFFFFFFFFFFF, 64'h0);
    end
  endtask

  task automatic test_write_disable;
    wr(5'd4, 64'h11);
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteRegister = 5'd4;
    WriteData     = 64'h99;
    @(posedge clk);
    #1;
    rd(5'd4, 5'd4);
    total++;
    if (ReadData1 !== 64'h11) begin
      bad++;
      $display("FAIL wr_disable got=%h want=%h", ReadData1, 64'h11);
    end
  endtask

  task automatic test_same_cycle;
    logic [63:0] pre_exp;
`ifdef REGFILE_BYPASS_EN
    pre_exp = 64'hB;
`else
    pre_exp = 64'hA;
`endif
    wr(5'd9, 64'hA);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd9;
    WriteData     = 64'hB;
    ReadRegister1 = 5'd9;
    ReadRegister2 = 5'd4;
    #1;
    total++;
    if (ReadData1 !== pre_exp) begin
      bad++;
      $display("FAIL same_cycle_pre got=%h want=%h", ReadData1, pre_exp);
    end
    total++;
    if (ReadData2 !== 64'h11) begin
      bad++;
      $display("FAIL same_cycle_other_port got=%h want=%h", ReadData2, 64'h11);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    total++;
    if (ReadData1 !== 64'hB) begin
      bad++;
      $display("FAIL same_cycle_post got=%h want=%h", ReadData1, 64'hB);
    end
  endtask

  task automatic test_reset_between_edges;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    rd(5'd9, 5'd3);
    total++;
    if (ReadData1 !== 64'hB || ReadData2 !== 64'h0123456789ABCDEF) begin
      bad++;
      $display("FAIL reset_glitch got=%h/%h want=%h/%h", ReadData1, ReadData2,
               64'hB, 64'h0123456789ABCDEF);
    end
  endtask

  task automatic test_reset_priority;
    wr(5'd2, 64'h44);
    @(negedge clk);
    reset         = 1'b0;
    RegWrite      = 1'b1;
    WriteRegister = 5'd2;
    WriteData     = 64'h77;
    ReadRegister1 = 5'd2;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    reset    = 1'b1;
    rd(5'd2, 5'd9);
    total++;
    if (ReadData1 !== 64'h0) begin
      bad++;
      $display("FAIL reset_prio_x2 got=%h want=%h", ReadData1, 64'h0);
    end
    total++;
    if (ReadData2 !== 64'h0) begin
      bad++;
      $display("FAIL reset_prio_x9 got=%h want=%h", ReadData2, 64'h0);
    end
    // first edge after deassert already accepts a write
    wr(5'd2, 64'h33);
    rd(5'd2, 5'd2);
    total++;
    if (ReadData1 !== 64'h33) begin
      bad++;
      $display("FAIL post_reset_write got=%h want=%h", ReadData1, 64'h33);
    end
  endtask

  task automatic test_all_regs;
    logic [63:0] pat;
    int errs;
    for (int i = 0; i < 32; i++) begin
      pat = {32'hA5A50000 + 32'(i), 32'h0F0F0000 ^ 32'(i * 7)};
      wr(5'(i), pat);
    end
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      pat = (i == 31) ? 64'h0 : {32'hA5A50000 + 32'(i), 32'h0F0F0000 ^ 32'(i * 7)};
      rd(5'(i), 5'(31 - i));
      if (ReadData1 !== pat) begin
        errs++;
        $display("FAIL all_regs_rd1[%0d] got=%h want=%h", i, ReadData1, pat);
      end
    end
    for (int i = 0; i < 32; i++) begin
      pat = (i == 31) ? 64'h0 : {32'hA5A50000 + 32'(i), 32'h0F0F0000 ^ 32'(i * 7)};
      rd(5'(31 - i), 5'(i));
      if (ReadData2 !== pat) begin
        errs++;
        $display("FAIL all_regs_rd2[%0d] got=%h want=%h", i, ReadData2, pat);
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL all_regs errors=%0d want=0", errs);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    test_reset();
    test_write_read();
    test_zero_reg();
    test_write_disable();
    test_same_cycle();
    test_reset_between_edges();
    test_reset_priority();
    test_all_regs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of each register and of read/write data.
REQ-002 SHALL have parameter DELAY, default 50 (ps), gate delay applied to every structural gate primitive in the block.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-low: sampled only on the clk rising edge, and asserted when 0.
REQ-005 SHALL have port RegWrite, input, 1, write enable.
REQ-006 SHALL have port WriteRegister, input, 5, destination register index.
REQ-007 SHALL have port WriteData, input, DATA_W, value to store.
REQ-008 SHALL have port ReadRegister1, input, 5, read port A index.
REQ-009 SHALL have port ReadRegister2, input, 5, read port B index.
REQ-010 SHALL have port ReadData1, output, DATA_W, contents of register ReadRegister1.
REQ-011 SHALL have port ReadData2, output, DATA_W, contents of register ReadRegister2.

Function
REQ-012 SHALL hold 32 registers X0..X31, each DATA_W bits wide.
REQ-013 SHALL write WriteData into X[WriteRegister] on the rising clk edge when RegWrite=1 and reset=1; all other registers hold their value.
REQ-014 SHALL leave all registers unchanged when RegWrite=0.
REQ-015 SHALL treat X31 as the zero register: writes to index 31 are discarded, and reads of index 31 return all zeros.
REQ-016 SHALL make reads combinational: ReadDataN reflects the addressed register via a 32:1 bitwise select tree, with no clock latency.
REQ-017 SHALL let a new written value appear on a read port only after the write edge (plus gate delays), unless REGFILE_BYPASS_EN applies.
REQ-018 SHALL serve both read ports independently; both may address the same register, or the write target, in the same cycle.
REQ-019 SHALL produce no X/Z on the outputs after reset for any valid address.

Reset
REQ-020 SHALL clear X0..X30 to 0 on the first rising edge with reset=0; ReadData1 and ReadData2 are then 0 for every address.
REQ-021 SHALL give reset priority over RegWrite: a write in a reset cycle is dropped.
REQ-022 SHALL have reset act only at clk edges; a reset pulse between edges has no effect.
REQ-023 SHALL, when reset is deasserted, accept writes starting with the next edge.

Configuration
REQ-024 SHALL use macro REGFILE_BYPASS_EN to enable write-to-read forwarding.
REQ-025 SHALL, with REGFILE_BYPASS_EN defined, when RegWrite=1, reset=1 and WriteRegister equals ReadRegisterN (N≠31), drive ReadDataN = WriteData combinationally in the same cycle.
REQ-026 SHALL, with REGFILE_BYPASS_EN undefined, omit the forwarding logic; reads return the stored value per REQ-017.

Structure
REQ-027 SHALL take DATA_W default, REG_COUNT=32, REG_ADDR_W=5 and ZERO_REG=31 from shared package cpu_pkg.
REQ-028 SHALL implement write-enable generation in one sub-module, decoder5_32 (5-bit index plus enable in, 32 one-hot enables out); register storage uses enabled DFF cells.
REQ-029 SHALL build read selection from the existing 32:1 single-bit mux, replicated DATA_W times per port.

Verification
REQ-030 SHALL cover reset: load X5=0xDEAD, assert reset=0 for one edge -> ReadData1(idx5)=0 and ReadData2(idx0)=0.
REQ-031 SHALL cover write/read: write X3=0x0123456789ABCDEF, then X7=0xFFFF_FFFF_FFFF_FFFF -> next cycle ReadData1(3) and ReadData2(7) return those values.
REQ-032 SHALL cover the zero register: write X31=0x55 -> ReadData1(31)=0 and no other register changes.
REQ-033 SHALL cover write disable: RegWrite=0 with WriteRegister=4, WriteData=0x99 -> X4 keeps its prior value 0x11.
REQ-034 SHALL cover same-cycle read of the write target: X9=0xA, write 0xB to X9 with ReadRegister1=9 -> 0xA before the edge (0xB if REGFILE_BYPASS_EN), and 0xB after the edge.
REQ-035 SHALL cover reset priority: reset=0 and RegWrite=1 (X2=0x77) on the same edge -> X2=0 after the edge.
